wbus_arbiter: RTL and testbench

Round-robin arbiter that shares the single W bus master port among up to NREQ CPU-side requesters (one per hardware thread's fetch/load unit). It grants one requester at a time, drives W_ADDR/W_DATA_O/W_WRITE/W_STB for that transaction, waits for W_ACK, and returns the read data with a one-cycle acknowledge pulse to the granted requester. It sits between the per-thread fetch units and the W bus, in the CPU clock domain.

---
 rtl/wbus_arbiter_if.sv | 31 +++
 rtl/wbus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_wbus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbus_arbiter_if.sv
// wbus_arbiter_if: requester-side and W-bus-side signals of the wbus_arbiter.
// The master modport is the arbiter's view: it consumes requests and drives the W bus.
// The slave modport is the surrounding logic's view: requesters plus the W bus target.
interface wbus_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_write;
  logic [32*NREQ-1:0]   req_addr;
  logic [32*NREQ-1:0]   req_data;
  logic [31:0]          rd_data;
  logic [NREQ-1:0]      req_ack;
  logic [NREQ-1:0]      req_err;
  logic                 busy;
  logic [31:0]          W_ADDR;
  logic [31:0]          W_DATA_O;
  logic                 W_WRITE;
  logic                 W_STB;
  logic                 W_ACK;
  logic [31:0]          W_DATA_I;

  modport master (
    input  req, req_write, req_addr, req_data, W_ACK, W_DATA_I,
    output rd_data, req_ack, req_err, busy, W_ADDR, W_DATA_O, W_WRITE, W_STB
  );

  modport slave (
    output req, req_write, req_addr, req_data, W_ACK, W_DATA_I,
    input  rd_data, req_ack, req_err, busy, W_ADDR, W_DATA_O, W_WRITE, W_STB
  );
endinterface

// File: rtl/wbus_arbiter.sv
// wbus_arbiter: round-robin arbiter sharing one W bus master port among NREQ
// requesters. One transaction at a time: IDLE picks a winner and launches the
// strobe, WAIT holds the bus until W_ACK, DONE pulses req_ack for one cycle.
// Optional feature macro: WBUS_ARB_TIMEOUT_EN -- aborts a WAIT that lasts TIMEOUT
// cycles without W_ACK, pulsing req_ack and req_err together with rd_data=0.
module wbus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  wbus_arbiter_if.master  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [PW-1:0]    win;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             write_q, write_d;
  logic             stb_q, stb_d;
  logic [31:0]      rd_q, rd_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  err_d;

  // First requester at or above the pointer, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
    logic [PW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        w     = PW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Pointer position just after the winner, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] w);
    return PW'((int'(w) + 1) % NREQ);
  endfunction

`ifdef WBUS_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]      cnt_q, cnt_d;
  logic [NREQ-1:0]  err_q;
`else
  logic [15:0]      unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
`endif

  // Next-state and next-output computation for the IDLE/WAIT/DONE controller.
  always_comb begin
    win     = rr_pick(bus.req, ptr_q);
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    stb_d   = stb_q;
    rd_d    = rd_q;
    ack_d   = '0;
    err_d   = '0;
`ifdef WBUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = win;
          ptr_d   = rr_next(win);
          addr_d  = bus.req_addr[32*int'(win) +: 32];
          wdata_d = bus.req_data[32*int'(win) +: 32];
          write_d = bus.req_write[win];
          stb_d   = 1'b1;
          state_d = WAIT;
`ifdef WBUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (bus.W_ACK) begin
          stb_d          = 1'b0;
          rd_d           = bus.W_DATA_I;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
`ifdef WBUS_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          // Abort: the requester still gets its one-cycle ack, flagged as an error.
          stb_d          = 1'b0;
          rd_d           = '0;
          ack_d[grant_q] = 1'b1;
          err_d[grant_q] = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller and bus registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      stb_q   <= 1'b0;
      rd_q    <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      stb_q   <= stb_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
    end
  end

`ifdef WBUS_ARB_TIMEOUT_EN
  // Wait-cycle counter and the error pulse that accompanies a timeout ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.req_err = err_q;
`else
  logic [NREQ-1:0] unused_err;
  assign unused_err  = err_d;
  assign bus.req_err = '0;
`endif

  assign bus.W_ADDR   = addr_q;
  assign bus.W_DATA_O = wdata_q;
  assign bus.W_WRITE  = write_q;
  assign bus.W_STB    = stb_q;
  assign bus.rd_data  = rd_q;
  assign bus.req_ack  = ack_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_wbus_arbiter.sv
// tb_wbus_arbiter: directed stimulus for wbus_arbiter with a queue-based
// scoreboard. Stimulus pushes the expected bus launch and the expected
// acknowledge; two monitors pop and compare when the DUT raises W_STB or req_ack.
module tb_wbus_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic        err;
  } ack_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } bus_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wbus_arbiter_if #(.NREQ(NREQ)) bus();

  wbus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ack_t ack_q[$];
  bus_t bus_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Acknowledge monitor
  ack_t            ae;
  logic [NREQ-1:0] exp_oh;
  always @(negedge clk) begin
    if (bus.req_ack != '0 || bus.req_err != '0) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", {56'd0, bus.req_err, bus.req_ack}, 64'd0);
      end else begin
        ae = ack_q.pop_front();
        exp_oh = '0;
        exp_oh[ae.idx] = 1'b1;
        chk("ack_onehot", 64'(bus.req_ack), 64'(exp_oh));
        chk("ack_rd_data", 64'(bus.rd_data), 64'(ae.rd));
        chk("ack_err", 64'(bus.req_err), ae.err ? 64'(exp_oh) : 64'd0);
      end
    end
  end

  // Bus-launch monitor
  bus_t be;
  logic stb_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.W_STB && !stb_prev) begin
      if (bus_q.size() == 0) begin
        chk("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        be = bus_q.pop_front();
        chk("bus_addr", 64'(bus.W_ADDR), 64'(be.addr));
        chk("bus_wdata", 64'(bus.W_DATA_O), 64'(be.data));
        chk("bus_write", 64'(bus.W_WRITE), 64'(be.wr));
      end
    end
    stb_prev <= bus.W_STB;
  end

  task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic w);
    bus_t b;
    b.addr = a; b.data = d; b.wr = w;
    bus_q.push_back(b);
  endtask

  task automatic push_ack(input int i, input logic [31:0] rd, input logic e);
    ack_t a;
    a.idx = i; a.rd = rd; a.err = e;
    ack_q.push_back(a);
  endtask

  task automatic post(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req_addr[32*i +: 32] = a;
    bus.req_data[32*i +: 32] = d;
    bus.req_write[i] = w;
    bus.req[i] = 1'b1;
  endtask

  task automatic wait_stb();
    int n = 0;
    while (!bus.W_STB && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stb_rise", 64'(bus.W_STB), 64'd1);
  endtask

  // Serve the granted requester: ack after 'dly' extra WAIT cycles, then drop its req in DONE.
  task automatic serve(input int i, input int dly, input logic [31:0] rdata);
    wait_stb();
    bus.req_addr[32*i +: 32] = 32'hDEAD_0000;
    bus.req_data[32*i +: 32] = 32'hDEAD_1111;
    repeat (dly) begin
      @(posedge clk); #1;
      chk("stb_hold", 64'(bus.W_STB), 64'd1);
    end
    bus.W_ACK = 1'b1;
    bus.W_DATA_I = rdata;
    @(posedge clk); #1;
    bus.W_ACK = 1'b0;
    bus.W_DATA_I = 32'hDEAD_BEEF;
    bus.req[i] = 1'b0;
    chk("stb_low_after_ack", 64'(bus.W_STB), 64'd0);
    chk("busy_in_done", 64'(bus.busy), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req = '0;
    bus.W_ACK = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] K = 32'h0F0F_0000;

  initial begin
    bus.req = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.W_ACK = 1'b0;
    bus.W_DATA_I = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stb", 64'(bus.W_STB), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ack", 64'(bus.req_ack), 64'd0);
    chk("rst_err", 64'(bus.req_err), 64'd0);
    chk("rst_addr", 64'(bus.W_ADDR), 64'd0);
    chk("rst_wdata", 64'(bus.W_DATA_O), 64'd0);
    chk("rst_write", 64'(bus.W_WRITE), 64'd0);
    chk("rst_rd", 64'(bus.rd_data), 64'd0);
    rst = 1'b0;

    // Single read, W_ACK three cycles after the launch
    post(0, 1'b0, 32'h1000_0040, 32'h0000_0000);
    push_bus(32'h1000_0040, 32'h0000_0000, 1'b0);
    push_ack(0, 32'hCAFE_0001, 1'b0);
    serve(0, 3, 32'hCAFE_0001);

    // Write from requester 2
    post(2, 1'b1, 32'h2000_0008, 32'h1234_5678);
    push_bus(32'h2000_0008, 32'h1234_5678, 1'b1);
    push_ack(2, 32'h0000_00A5, 1'b0);
    serve(2, 1, 32'h0000_00A5);

    // Stray W_ACK while idle
    repeat (3) begin
      @(posedge clk); #1;
      bus.W_ACK = 1'b1;
      bus.W_DATA_I = 32'h5555_5555;
      @(posedge clk); #1;
      chk("stray_busy", 64'(bus.busy), 64'd0);
      chk("stray_stb", 64'(bus.W_STB), 64'd0);
      chk("stray_ack", 64'(bus.req_ack), 64'd0);
      bus.W_ACK = 1'b0;
    end

    // Reset in the middle of a WAIT for requester 1, with W_ACK on the same edge
    post(1, 1'b0, 32'h3000_0010, 32'h0000_0000);
    push_bus(32'h3000_0010, 32'h0000_0000, 1'b0);
    wait_stb();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.W_ACK = 1'b1;
    bus.W_DATA_I = 32'h6666_6666;
    @(posedge clk); #1;
    chk("midrst_stb", 64'(bus.W_STB), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_ack", 64'(bus.req_ack), 64'd0);
    chk("midrst_addr", 64'(bus.W_ADDR), 64'd0);
    rst = 1'b0;
    bus.W_ACK = 1'b0;
    // Requesters 0,1,2 pending: a reset pointer starts at 0, then 1, then 2
    post(0, 1'b0, 32'h3000_0020, 32'h0000_0000);
    post(2, 1'b0, 32'h3000_0030, 32'h0000_0000);
    push_bus(32'h3000_0020, 32'h0000_0000, 1'b0);
    push_bus(32'h3000_0010, 32'h0000_0000, 1'b0);
    push_bus(32'h3000_0030, 32'h0000_0000, 1'b0);
    push_ack(0, 32'h7700_0000, 1'b0);
    push_ack(1, 32'h7700_0001, 1'b0);
    push_ack(2, 32'h7700_0002, 1'b0);
    serve(0, 0, 32'h7700_0000);
    serve(1, 2, 32'h7700_0001);
    serve(2, 0, 32'h7700_0002);

    // Fairness: all four held, W_ACK held high -> grants 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[32*i +: 32] = 32'h4000_0000 + 32'(i * 16);
      bus.req_data[32*i +: 32] = 32'h5000_0000 + 32'(i);
    end
    bus.req_write = 4'b1010;
    push_bus(32'h4000_0000, 32'h5000_0000, 1'b0);
    push_bus(32'h4000_0010, 32'h5000_0001, 1'b1);
    push_bus(32'h4000_0020, 32'h5000_0002, 1'b0);
    push_bus(32'h4000_0030, 32'h5000_0003, 1'b1);
    push_bus(32'h4000_0000, 32'h5000_0000, 1'b0);
    push_ack(0, 32'h4F0F_0000, 1'b0);
    push_ack(1, 32'h4F0F_0010, 1'b0);
    push_ack(2, 32'h4F0F_0020, 1'b0);
    push_ack(3, 32'h4F0F_0030, 1'b0);
    push_ack(0, 32'h4F0F_0000, 1'b0);
    bus.req = 4'b1111;
    bus.W_ACK = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      bus.W_DATA_I = bus.W_ADDR ^ K;
    end
    bus.req = '0;
    bus.W_ACK = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fair_idle_busy", 64'(bus.busy), 64'd0);
    chk("fair_acks_drained", 64'(ack_q.size()), 64'd0);

    // Requester 3 never acknowledged by the bus
    post(3, 1'b0, 32'h6000_0000, 32'h0000_0000);
    push_bus(32'h6000_0000, 32'h0000_0000, 1'b0);
    wait_stb();
`ifdef WBUS_ARB_TIMEOUT_EN
    push_ack(3, 32'h0000_0000, 1'b1);
    repeat (TIMEOUT - 1) begin
      @(posedge clk); #1;
      chk("to_stb_hold", 64'(bus.W_STB), 64'd1);
    end
    @(posedge clk); #1;
    chk("to_stb_low", 64'(bus.W_STB), 64'd0);
    bus.req = '0;
    @(posedge clk); #1;
    chk("to_idle_busy", 64'(bus.busy), 64'd0);
`else
    repeat (20) begin
      @(posedge clk); #1;
      chk("noto_stb_hold", 64'(bus.W_STB), 64'd1);
      chk("noto_busy", 64'(bus.busy), 64'd1);
    end
    do_reset();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("ack_queue_empty", 64'(ack_q.size()), 64'd0);
    chk("bus_queue_empty", 64'(bus_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
